// File: rtl/dac_out_fmt.sv
// dac_out_fmt: formats modulator samples for a dual DAC.
//   Per channel: round/shift, saturate, soft-mute gain, then offset-binary or
//   two's-complement coding. Output modes: differential (DB = ~DA), dual
//   channel, free-running test ramp, or midscale. Three pipeline stages.
// Ports:
//   sys_clk, Rst         clock; asynchronous active-low reset
//   din_valid            din_a/din_b carry a sample this cycle
//   din_a, din_b         signed input samples (din_b used in dual mode only)
//   mode                 00 diff, 01 dual, 10 test ramp, 11 midscale
//   fmt_offset           1: offset binary (MSB inverted), 0: two's complement
//   mute_req             level request to ramp the gain down to zero
//   cnt_clr              synchronous clear of sat_cnt/sat_flag
//   DA, DB, dout_valid   DAC codes and new-sample strobe
//   mute_done            high while fully muted
//   sat_flag, sat_cnt    sticky saturation flag and saturating event counter
module dac_out_fmt #(
  parameter int unsigned DIN_W     = 30,
  parameter int unsigned DAC_W     = 14,
  parameter int unsigned SHIFT     = 7,
  parameter int unsigned GAIN_W    = 8,
  parameter int unsigned RAMP_STEP = 1,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             sys_clk,
  input  logic             Rst,
  input  logic             din_valid,
  input  logic [DIN_W-1:0] din_a,
  input  logic [DIN_W-1:0] din_b,
  input  logic [1:0]       mode,
  input  logic             fmt_offset,
  input  logic             mute_req,
  input  logic             cnt_clr,
  output logic [DAC_W-1:0] DA,
  output logic [DAC_W-1:0] DB,
  output logic             dout_valid,
  output logic             mute_done,
  output logic             sat_flag,
  output logic [CNT_W-1:0] sat_cnt
);

  localparam int unsigned RW = DIN_W - SHIFT + 1;  // rounded sample width
  localparam int unsigned GW = GAIN_W + 1;         // gain 0..2**GAIN_W
  localparam int unsigned PW = DAC_W + GW + 1;     // signed product width
  localparam int unsigned YW = PW - GAIN_W;        // product after >>> GAIN_W
  localparam int unsigned WW = (RW > YW) ? RW : YW;

  localparam logic [1:0] ModeDiff = 2'b00;
  localparam logic [1:0] ModeDual = 2'b01;
  localparam logic [1:0] ModeRamp = 2'b10;
  localparam logic [1:0] ModeMid  = 2'b11;

  localparam logic [GW-1:0]           GainUnity = {1'b1, {GAIN_W{1'b0}}};
  localparam logic [GW-1:0]           GainStep  = GW'(RAMP_STEP);
  localparam logic [DIN_W:0]          RoundHalf = (DIN_W + 1)'(1) << (SHIFT - 1);
  localparam logic signed [DAC_W-1:0] DacMax    = {1'b0, {(DAC_W - 1){1'b1}}};
  localparam logic signed [DAC_W-1:0] DacMin    = {1'b1, {(DAC_W - 1){1'b0}}};
  localparam logic [CNT_W-1:0]        CntMax    = '1;

  typedef enum logic [1:0] {StActive, StRampDn, StMuted, StRampUp} mute_state_e;

  // Returns {clamped, code}.
  function automatic logic [DAC_W:0] clamp_dac(input logic signed [WW-1:0] v);
    if (v > WW'(DacMax)) begin
      return {1'b1, DacMax};
    end else if (v < WW'(DacMin)) begin
      return {1'b1, DacMin};
    end else begin
      return {1'b0, v[DAC_W-1:0]};
    end
  endfunction

  function automatic logic [DAC_W-1:0] fmt_code(input logic [DAC_W-1:0] v, input logic offs);
    return {v[DAC_W-1] ^ offs, v[DAC_W-2:0]};
  endfunction

  // Stage 1: round half toward +inf. One guard bit keeps x + half from overflowing.
  logic signed [DIN_W:0] sum_a, sum_b;
  always_comb begin
    sum_a = $signed({din_a[DIN_W-1], din_a}) + $signed(RoundHalf);
    sum_b = $signed({din_b[DIN_W-1], din_b}) + $signed(RoundHalf);
  end

  logic                 s1_valid_q, s1_fmt_q;
  logic [1:0]           s1_mode_q;
  logic signed [RW-1:0] s1_a_q, s1_b_q;

  // Stage 2: saturate, gain, re-clamp.
  logic [GW-1:0]        gain_q, gain_d;
  logic [DAC_W:0]       clp_a, clp_b, gcl_a, gcl_b;
  logic signed [PW-1:0] prod_a, prod_b;
  logic                 sat_evt;

  always_comb begin
    clp_a  = clamp_dac(WW'(s1_a_q));
    clp_b  = clamp_dac(WW'(s1_b_q));
    prod_a = PW'($signed(clp_a[DAC_W-1:0])) * $signed({{(PW - GW){1'b0}}, gain_q});
    prod_b = PW'($signed(clp_b[DAC_W-1:0])) * $signed({{(PW - GW){1'b0}}, gain_q});
    gcl_a  = clamp_dac(WW'($signed(prod_a[PW-1:GAIN_W])));
    gcl_b  = clamp_dac(WW'($signed(prod_b[PW-1:GAIN_W])));
    // Only input clamping counts; channel B matters in dual mode only.
    sat_evt = s1_valid_q &&
              (((s1_mode_q == ModeDiff) && clp_a[DAC_W]) ||
               ((s1_mode_q == ModeDual) && (clp_a[DAC_W] || clp_b[DAC_W])));
  end

  logic [CNT_W-1:0] sat_cnt_q, sat_cnt_d;
  logic             sat_flag_q, sat_flag_d;

  always_comb begin
    sat_cnt_d  = sat_cnt_q;
    sat_flag_d = sat_flag_q;
    if (cnt_clr) begin
      // A coincident event survives the clear.
      sat_cnt_d  = sat_evt ? CNT_W'(1) : '0;
      sat_flag_d = sat_evt;
    end else if (sat_evt) begin
      sat_flag_d = 1'b1;
      if (sat_cnt_q != CntMax) sat_cnt_d = sat_cnt_q + 1'b1;
    end
  end

  logic             s2_valid_q, s2_fmt_q;
  logic [1:0]       s2_mode_q;
  logic [DAC_W-1:0] s2_a_q, s2_b_q;

  // Stage 3: coding and output mode selection.
  logic [DAC_W-1:0] da_q, da_d, db_q, db_d, ramp_q, ramp_d;
  logic             dv_q, dv_d;

  always_comb begin
    da_d   = da_q;
    db_d   = db_q;
    dv_d   = 1'b0;
    ramp_d = ramp_q;
    unique case (s2_mode_q)
      ModeDiff: begin
        if (s2_valid_q) begin
          da_d = fmt_code(s2_a_q, s2_fmt_q);
          db_d = ~fmt_code(s2_a_q, s2_fmt_q);
          dv_d = 1'b1;
        end
      end
      ModeDual: begin
        if (s2_valid_q) begin
          da_d = fmt_code(s2_a_q, s2_fmt_q);
          db_d = fmt_code(s2_b_q, s2_fmt_q);
          dv_d = 1'b1;
        end
      end
      ModeRamp: begin
        // Counter advances once per emitted ramp code, i.e. every cycle in this mode.
        da_d   = ramp_q;
        db_d   = ~ramp_q;
        ramp_d = ramp_q + 1'b1;
        dv_d   = 1'b1;
      end
      ModeMid: begin
        da_d = fmt_code('0, s2_fmt_q);
        db_d = fmt_code('0, s2_fmt_q);
        dv_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge Rst) begin
    if (!Rst) begin
      s1_valid_q <= 1'b0;
      s1_fmt_q   <= 1'b0;
      s1_mode_q  <= ModeDiff;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s2_valid_q <= 1'b0;
      s2_fmt_q   <= 1'b0;
      s2_mode_q  <= ModeDiff;
      s2_a_q     <= '0;
      s2_b_q     <= '0;
      sat_cnt_q  <= '0;
      sat_flag_q <= 1'b0;
      da_q       <= '0;
      db_q       <= '0;
      dv_q       <= 1'b0;
      ramp_q     <= '0;
    end else begin
      s1_valid_q <= din_valid;
      s1_fmt_q   <= fmt_offset;
      s1_mode_q  <= mode;
      s1_a_q     <= sum_a[DIN_W:SHIFT];
      s1_b_q     <= sum_b[DIN_W:SHIFT];
      s2_valid_q <= s1_valid_q;
      s2_fmt_q   <= s1_fmt_q;
      s2_mode_q  <= s1_mode_q;
      s2_a_q     <= gcl_a[DAC_W-1:0];
      s2_b_q     <= gcl_b[DAC_W-1:0];
      sat_cnt_q  <= sat_cnt_d;
      sat_flag_q <= sat_flag_d;
      da_q       <= da_d;
      db_q       <= db_d;
      dv_q       <= dv_d;
      ramp_q     <= ramp_d;
    end
  end

  // Soft-mute FSM: state register.
  mute_state_e state_q, state_d;

  always_ff @(posedge sys_clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= StActive;
      gain_q  <= GainUnity;
    end else begin
      state_q <= state_d;
      gain_q  <= gain_d;
    end
  end

  // Next state and gain. A reversal edge only changes direction; gain moves next cycle.
  always_comb begin
    state_d = state_q;
    gain_d  = gain_q;
    unique case (state_q)
      StActive: begin
        if (mute_req) state_d = StRampDn;
      end
      StRampDn: begin
        if (!mute_req) begin
          state_d = StRampUp;
        end else if (gain_q <= GainStep) begin
          gain_d  = '0;
          state_d = StMuted;
        end else begin
          gain_d = gain_q - GainStep;
        end
      end
      StMuted: begin
        if (!mute_req) state_d = StRampUp;
      end
      StRampUp: begin
        if (mute_req) begin
          state_d = StRampDn;
        end else if (gain_q >= GainUnity - GainStep) begin
          gain_d  = GainUnity;
          state_d = StActive;
        end else begin
          gain_d = gain_q + GainStep;
        end
      end
    endcase
  end

  // Outputs.
  always_comb begin
    mute_done = (state_q == StMuted);
  end

  assign DA         = da_q;
  assign DB         = db_q;
  assign dout_valid = dv_q;
  assign sat_flag   = sat_flag_q;
  assign sat_cnt    = sat_cnt_q;

endmodule

// File: tb/tb_dac_out_fmt.sv
// Randomised scoreboard bench for dac_out_fmt (default parameters).
// The driver computes each expected DA/DB pair from arithmetic rules and pushes
// it; a negedge monitor pops and compares whenever dout_valid is high.
module tb_dac_out_fmt;

  logic        sys_clk = 1'b0;
  logic        Rst = 1'b0;
  logic        din_valid = 1'b0;
  logic [29:0] din_a = '0;
  logic [29:0] din_b = '0;
  logic [1:0]  mode = 2'b00;
  logic        fmt_offset = 1'b1;
  logic        mute_req = 1'b0;
  logic        cnt_clr = 1'b0;
  logic [13:0] DA, DB;
  logic        dout_valid, mute_done, sat_flag;
  logic [15:0] sat_cnt;

  dac_out_fmt dut (
    .sys_clk    (sys_clk),
    .Rst        (Rst),
    .din_valid  (din_valid),
    .din_a      (din_a),
    .din_b      (din_b),
    .mode       (mode),
    .fmt_offset (fmt_offset),
    .mute_req   (mute_req),
    .cnt_clr    (cnt_clr),
    .DA         (DA),
    .DB         (DB),
    .dout_valid (dout_valid),
    .mute_done  (mute_done),
    .sat_flag   (sat_flag),
    .sat_cnt    (sat_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [13:0] da;
    logic [13:0] db;
  } exp_t;

  exp_t sb_q[$];
  int   n_chk = 0;
  int   n_fail = 0;

  // Reference state: gain 0..256, mute condition, ramp value, saturation stats.
  localparam int Unity = 256;
  localparam int MActive = 0, MDown = 1, MMuted = 2, MUp = 3;
  int m_gain = Unity;
  int m_state = MActive;
  int m_ramp = 0;
  int m_cnt = 0;
  bit m_flag = 1'b0;
  bit m_pend = 1'b0;  // saturation of the sample that reaches the counter next edge

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int rnd(input int x);
    return int'((longint'(x) + 64) >>> 7);
  endfunction

  function automatic bit oob(input int v);
    return (v > 8191) || (v < -8192);
  endfunction

  function automatic int clampv(input int v);
    if (v > 8191) return 8191;
    if (v < -8192) return -8192;
    return v;
  endfunction

  function automatic int gained(input int s, input int g);
    return clampv(int'((longint'(s) * g) >>> 8));
  endfunction

  function automatic logic [13:0] code(input int v, input bit off);
    logic [13:0] c;
    c = 14'(v);
    if (off) c[13] = ~c[13];
    return c;
  endfunction

  // Gain behaviour for one clock edge with the given mute request.
  task automatic mstep(input bit mr);
    case (m_state)
      MActive: if (mr) m_state = MDown;
      MDown: begin
        if (!mr) m_state = MUp;
        else begin
          m_gain = (m_gain > 1) ? m_gain - 1 : 0;
          if (m_gain == 0) m_state = MMuted;
        end
      end
      MMuted: if (!mr) m_state = MUp;
      default: begin
        if (mr) m_state = MDown;
        else begin
          m_gain = (m_gain < Unity - 1) ? m_gain + 1 : Unity;
          if (m_gain == Unity) m_state = MActive;
        end
      end
    endcase
  endtask

  // Apply inputs for one cycle, predict, clock, then check the status outputs.
  task automatic drive(input bit v, input int a, input int b, input bit [1:0] md, input bit off,
                       input bit mr, input bit clr);
    int   ra, rb, ya, yb;
    exp_t e;
    din_valid  = v;
    din_a      = a[29:0];
    din_b      = b[29:0];
    mode       = md;
    fmt_offset = off;
    mute_req   = mr;
    cnt_clr    = clr;
    // The sample's gain stage runs one edge later, using the gain left by this edge.
    mstep(mr);
    if (clr) begin
      m_cnt  = m_pend ? 1 : 0;
      m_flag = m_pend;
    end else if (m_pend) begin
      if (m_cnt < 65535) m_cnt++;
      m_flag = 1'b1;
    end
    ra = rnd(a);
    rb = rnd(b);
    m_pend = v && (((md == 2'b00) && oob(ra)) || ((md == 2'b01) && (oob(ra) || oob(rb))));
    ya = gained(clampv(ra), m_gain);
    yb = gained(clampv(rb), m_gain);
    case (md)
      2'b00: if (v) begin e.da = code(ya, off); e.db = ~code(ya, off); sb_q.push_back(e); end
      2'b01: if (v) begin e.da = code(ya, off); e.db = code(yb, off); sb_q.push_back(e); end
      2'b10: begin
        e.da = 14'(m_ramp);
        e.db = ~e.da;
        sb_q.push_back(e);
        m_ramp = (m_ramp + 1) % 16384;
      end
      default: begin e.da = code(0, off); e.db = e.da; sb_q.push_back(e); end
    endcase
    @(posedge sys_clk);
    #1;
    chk("sat_cnt", sat_cnt, m_cnt);
    chk("sat_flag", sat_flag, m_flag);
    chk("mute_done", mute_done, m_state == MMuted);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 0, 0, 2'b00, 1'b1, 1'b0, 1'b0);
  endtask

  // Issue one sample, wait out the latency and compare against fixed codes.
  task automatic directed(input string name, input int a, input int b, input bit [1:0] md,
                          input bit off, input logic [13:0] xa, input logic [13:0] xb);
    drive(1'b1, a, b, md, off, 1'b0, 1'b0);
    idle(2);
    chk({name, "_da"}, DA, xa);
    chk({name, "_db"}, DB, xb);
    chk({name, "_valid"}, dout_valid, 1'b1);
  endtask

  function automatic int rand_din();
    logic [29:0] r;
    r = 30'($urandom);
    case ($urandom_range(0, 3))
      0: return $signed(r) >>> 17;
      1: return $signed(r) >>> 9;
      2: return int'($signed(r));
      default: return ($signed(r) >>> 22) * 128 + 63 + int'($urandom_range(0, 2));
    endcase
  endfunction

  // Monitor: scoreboard pop on every output strobe, hold check otherwise.
  logic [13:0] last_da = '0;
  logic [13:0] last_db = '0;
  always @(negedge sys_clk) begin
    exp_t e;
    if (!Rst) begin
      last_da = '0;
      last_db = '0;
    end else if (dout_valid) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_output", 1, 0);
      end else begin
        e = sb_q.pop_front();
        chk("da", DA, e.da);
        chk("db", DB, e.db);
      end
      last_da = DA;
      last_db = DB;
    end else begin
      chk("hold_da", DA, last_da);
      chk("hold_db", DB, last_db);
    end
  end

  initial begin
    bit [1:0] md;
    bit       mr;
    // Reset state.
    #3;
    chk("rst_da", DA, 0);
    chk("rst_db", DB, 0);
    chk("rst_valid", dout_valid, 0);
    chk("rst_sat_cnt", sat_cnt, 0);
    chk("rst_sat_flag", sat_flag, 0);
    chk("rst_mute_done", mute_done, 0);
    @(posedge sys_clk);
    #1 Rst = 1'b1;

    // Basic coding and rounding.
    directed("diff_1000", 128000, 0, 2'b00, 1'b1, 14'd9192, 14'd7191);
    directed("rnd_191", 191, 0, 2'b00, 1'b1, 14'd8193, 14'd8190);
    directed("rnd_192", 192, 0, 2'b00, 1'b1, 14'd8194, 14'd8189);
    directed("rnd_m64", -64, 0, 2'b00, 1'b1, 14'd8192, 14'd8191);
    directed("rnd_m192_2c", -192, 0, 2'b00, 1'b0, 14'd16383, 14'd0);

    // Saturation and counter clear.
    directed("sat_pos", 1 << 27, 0, 2'b00, 1'b1, 14'd16383, 14'd0);
    directed("sat_neg", -(1 << 27), 0, 2'b00, 1'b1, 14'd0, 14'd16383);
    chk("sat_cnt_2", sat_cnt, 2);
    chk("sat_flag_1", sat_flag, 1);
    drive(1'b0, 0, 0, 2'b00, 1'b1, 1'b0, 1'b1);
    chk("clr_cnt", sat_cnt, 0);
    chk("clr_flag", sat_flag, 0);
    drive(1'b1, 1 << 27, 0, 2'b00, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 0, 0, 2'b00, 1'b1, 1'b0, 1'b1);
    chk("clr_coinc_cnt", sat_cnt, 1);
    chk("clr_coinc_flag", sat_flag, 1);
    idle(3);

    // Dual mode and a valid gap.
    directed("dual", 12800, -12800, 2'b01, 1'b1, 14'd8292, 14'd8092);
    idle(1);
    chk("gap_valid", dout_valid, 0);
    chk("gap_hold_da", DA, 8292);

    // Midscale in both codings.
    drive(1'b0, 0, 0, 2'b11, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 0, 0, 2'b11, 1'b0, 1'b0, 1'b0);
    idle(1);
    chk("mid_off", DA, 8192);
    idle(1);
    chk("mid_2c", DB, 0);
    idle(2);

    // Mute ramp down, up, and reversals mid-ramp.
    for (int i = 0; i < 300; i++) drive(1'b1, 128000, 0, 2'b00, 1'b1, 1'b1, 1'b0);
    chk("muted_da", DA, 8192);
    chk("muted_done", mute_done, 1);
    for (int i = 0; i < 300; i++) drive(1'b1, 128000, 0, 2'b00, 1'b1, 1'b0, 1'b0);
    chk("unmuted_da", DA, 9192);
    chk("unmuted_done", mute_done, 0);
    for (int i = 0; i < 100; i++) drive(1'b1, -128000, 0, 2'b00, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 50; i++) drive(1'b1, -128000, 0, 2'b00, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 30; i++) drive(1'b1, 128000, 0, 2'b01, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 300; i++) drive(1'b1, 128000, 0, 2'b00, 1'b1, 1'b0, 1'b0);

    // Random traffic; mute_req changes rarely so ramps partly complete.
    mr = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 2) mr = ~mr;
      case ($urandom_range(0, 9))
        0: md = 2'b10;
        1: md = 2'b11;
        2, 3, 4, 5: md = 2'b00;
        default: md = 2'b01;
      endcase
      drive(1'($urandom_range(0, 3) != 0), rand_din(), rand_din(), md, 1'($urandom),
            mr, 1'($urandom_range(0, 49) == 0));
    end
    for (int i = 0; i < 300; i++) drive(1'b0, 0, 0, 2'b00, 1'b1, 1'b0, 1'b0);

    // Test ramp, asynchronous reset mid-ramp, then a full wrap.
    for (int i = 0; i < 120; i++) drive(1'b0, 0, 0, 2'b10, 1'b0, 1'b0, 1'b0);
    #2 Rst = 1'b0;
    #1;
    chk("async_rst_da", DA, 0);
    chk("async_rst_db", DB, 0);
    chk("async_rst_valid", dout_valid, 0);
    sb_q.delete();
    m_gain = Unity;
    m_state = MActive;
    m_ramp = 0;
    m_cnt = 0;
    m_flag = 1'b0;
    m_pend = 1'b0;
    @(posedge sys_clk);
    #1 Rst = 1'b1;
    for (int i = 0; i < 3; i++) drive(1'b0, 0, 0, 2'b10, 1'b0, 1'b0, 1'b0);
    chk("ramp_first_da", DA, 0);
    chk("ramp_first_db", DB, 16383);
    for (int i = 0; i < 16400; i++) drive(1'b0, 0, 0, 2'b10, 1'b1, 1'b0, 1'b0);
    idle(5);
    chk("scoreboard_empty", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
